// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with a start/busy/done handshake.
// bcd_out holds the last complete result, so a downstream display never sees partial values.
module bin_to_bcd_seq #(
    parameter int unsigned N_BITS   = 27,
    parameter int unsigned N_DIGITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [N_BITS-1:0]     bin_in,
    output logic [4*N_DIGITS-1:0] bcd_out,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned BcdW = 4 * N_DIGITS;
    localparam int unsigned CntW = $clog2(N_BITS + 1);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] OvfLimit = pow10(N_DIGITS);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state;
    logic [N_BITS-1:0] bin_sr;
    logic [BcdW-1:0]   acc;
    logic [BcdW-1:0]   acc_adj;
    logic [CntW-1:0]   cnt;
    logic              ovf_pending;
    logic              in_ovf;

    // Compare at full width so values between 10^N_DIGITS and 2^N_BITS-1 are caught.
    assign in_ovf = (64'(bin_in) >= OvfLimit);

    always_comb begin
        acc_adj = acc;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            bin_sr      <= '0;
            acc         <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            bcd_out     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        bin_sr      <= bin_in;
                        acc         <= '0;
                        cnt         <= CntW'(N_BITS);
                        ovf_pending <= in_ovf;
                        busy        <= 1'b1;
                        state       <= StShift;
                    end
                end
                StShift: begin
                    acc    <= {acc_adj[BcdW-2:0], bin_sr[N_BITS-1]};
                    bin_sr <= {bin_sr[N_BITS-2:0], 1'b0};
                    cnt    <= cnt - CntW'(1);
                    if (cnt == CntW'(1)) begin
                        state <= StDone;
                    end
                end
                StDone: begin
                    bcd_out  <= ovf_pending ? {N_DIGITS{4'h9}} : acc;
                    overflow <= ovf_pending;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble).
- Sits directly upstream of the 8-digit multiplexed 7-segment display driver.
- Its bcd_out drives the driver's 32-bit HEX_in, so a binary count or measurement shows as decimal digits.
- Uses a start/busy/done handshake. bcd_out holds the last valid result while a new conversion runs, so the display never shows partial values.

Parameters:
- N_BITS, 27, width of binary input. 2^27 covers 0..99,999,999.
- N_DIGITS, 8, number of BCD digits produced; output width = 4*N_DIGITS.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request conversion; sampled only in IDLE.
- bin_in  input  N_BITS  unsigned binary value; latched on accepted start.
- bcd_out  output  4*N_DIGITS  packed BCD result; digit 0 (units) in [3:0], digit 7 in [31:28]. Registered.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out has just been updated.
- overflow  output  1  registered with bcd_out; 1 if the last input was >= 10^N_DIGITS.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, bcd_out=0, busy=0, done=0, overflow=0. Internal shift register and counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1: latch bin_in into the binary shift register, clear the BCD accumulator, load the counter with N_BITS, set busy=1, go to SHIFT.
  - Also latch ovf_pending = (bin_in >= 10^N_DIGITS), compared at full width.
- SHIFT, one iteration per clock:
  - For each 4-bit accumulator digit, add 3 if digit >= 5.
  - Shift {accumulator, binary} left by 1; binary MSB enters accumulator bit 0.
  - Decrement the counter. After the N_BITS-th iteration, go to DONE.
- DONE, one cycle; on the next edge:
  - If ovf_pending=0: bcd_out <= accumulator, overflow <= 0.
  - If ovf_pending=1: bcd_out <= all digits 9 (0x99999999 at defaults), overflow <= 1.
  - done <= 1 for exactly one cycle, busy <= 0, state <= IDLE.
- Latency: start accepted at edge E0. busy=1 after E0. Shifts occur at E1..E_N_BITS. bcd_out, overflow and done update at E_(N_BITS+1), which is 28 edges at defaults.
- busy falls on the same edge that done rises.
- start while busy (SHIFT or DONE) is ignored; no queuing, and bin_in changes have no effect.
- start=1 in the cycle done is high is a new request (state is IDLE) and is accepted; back-to-back conversions are allowed.
- start held high continuously gives a new conversion every N_BITS+2 cycles.
- bcd_out and overflow change only on the DONE->IDLE edge or on reset. Between updates they hold their previous values.
- Reset asserted mid-conversion aborts immediately: outputs return to reset values and no done pulse is generated.
- Each produced digit is always within 0..9. Overflow is never generated by the arithmetic; it comes only from the latched input comparison.

Test Plan:
- Reset held 12 ns, then released; bin_in=123456, start pulsed 1 cycle -> busy=1 for 28 cycles, then done pulses once, bcd_out=0x00123456, overflow=0.
- bin_in=0 -> bcd_out=0x00000000 after 28 cycles. Then bin_in=99999999 -> bcd_out=0x99999999, overflow=0.
- bin_in=100000000 -> bcd_out=0x99999999, overflow=1. Next conversion with bin_in=7 -> bcd_out=0x00000007, overflow=0.
- Start 123456, then start pulses with bin_in=555 at cycles 5 and 20 -> both ignored, result 0x00123456. bcd_out keeps its prior value through the whole conversion.
- start held high with bin_in alternating 42/1000 -> done every 29 cycles. bcd_out alternates 0x00000042 / 0x00001000.
- reset driven low at cycle 10 of a conversion of 876543 -> bcd_out=0, busy=0, done=0 immediately. No done pulse afterwards. A subsequent start completes normally.
